steer_quad_gen: RTL and testbench
=================================

// Module: steer_quad_gen
// PURPOSE
//  Converts steering requests into the 2-bit quadrature pair the Sprint 2 core reads on its Steer_xA/Steer_xB inputs.
//  Sources are digital left/right (keyboard or d-pad) or a signed analog stick axis.
//  Analog deflection sets the step rate proportionally; there is one instance per player.
//  Sits between hps_io/keyboard decode and the sprint2 core, in the CLK_VIDEO_2 (6 MHz) domain.
// PARAMETERS
//  CLKDIV_MAX  22500  step period, clock cycles, at minimum deflection and for digital steering
//  CLKDIV_MIN  2000   lower clamp on the step period (full deflection)
//  DEADZONE    8      analog magnitude <= DEADZONE is treated as centred (range 0..126)
// PORTS
//  CLK         in   1   clock
//  reset       in   1   asynchronous, active-high
//  left        in   1   digital steer left
//  right       in   1   digital steer right
//  use_analog  in   1   1 = honour analog_x when no digital request is active
//  analog_x    in   8   signed stick axis; negative = left
//  steer       out  2   quadrature {A,B} to core (steer[1] = A)
//  moving      out  1   1 while a direction is being stepped
// BEHAVIOUR
//  Reset values: steer=2'b00, moving=0, internal counter=0, dir=IDLE, period=CLKDIV_MAX.
//  Stage 1 (request register, updated every clock):
//   - left^right=1: dir = LEFT or RIGHT; period = CLKDIV_MAX. Digital input overrides analog.
//   - left&right=1: dir = IDLE (both pressed cancel). Analog is ignored in this case.
//   - Neither pressed, use_analog=1: mag = |analog_x|, with -128 saturating to 127.
//     - mag <= DEADZONE: dir = IDLE.
//     - Otherwise dir = sign of analog_x (negative = LEFT).
//     - period = CLKDIV_MAX - (((mag-DEADZONE)*(CLKDIV_MAX-CLKDIV_MIN)) >> 7), clamped to >= CLKDIV_MIN.
//     - Intermediate product is unsigned and at least 7+clog2(CLKDIV_MAX+1) bits wide, with no truncation before the shift.
//   - Neither pressed, use_analog=0: dir = IDLE.
//  Stage 2 (step engine, uses stage-1 registers):
//   - States IDLE, RUN_L, RUN_R; the state follows the registered dir every cycle.
//   - IDLE: counter held at 0; steer holds its last phase; moving=0.
//   - RUN_x: moving=1; counter increments each clock.
//     - When counter >= period-1: counter <= 0 and phase advances one step.
//   - RIGHT sequence: 00->01->11->10->00. LEFT is the reverse sequence. Exactly one bit changes per step.
//   - Direction change (RUN_L<->RUN_R) or entry from IDLE: counter <= 0 on that cycle with no step.
//   - Period change while running: the new period applies immediately via the >= compare.
//     If counter already >= new period-1, the step occurs on the next edge.
//  Latency:
//   - Input change is reflected in stage 1 after 1 edge.
//   - First step comes exactly period edges after the edge on which stage-1 dir became non-IDLE.
//   - Steady-state step interval is exactly period cycles.
//  reset asserted mid-run: all state returns to reset values immediately (async). The engine restarts from IDLE after release.
//  steer is a registered output with no glitches; it is never driven combinationally from inputs.
// TESTING
//  (Bench parameters: CLKDIV_MAX=36, CLKDIV_MIN=4, DEADZONE=8.)
//  1. Reset: assert reset mid-run with steer=11 -> steer=00 and moving=0 at once; no step for 36 cycles after release with inputs idle.
//  2. right=1 held -> moving=1; steer goes 01,11,10,00 at 36-cycle intervals; first change 36 edges after dir registers.
//  3. left=1 for 2 steps, then right=1 (left=0) -> steer 00->10->11; on reversal counter resets; 36 cycles later steer=10.
//  4. Analog (use_analog=1):
//     - analog_x=+127 -> step every 7 cycles.
//     - analog_x=+72 -> every 20.
//     - analog_x=+9 -> every 36.
//     - analog_x=-128 -> LEFT every 7.
//     - analog_x=+8 or -8 -> moving=0, steer frozen.
//  5. left=right=1 with analog_x=+127 -> IDLE, steer frozen. Release left -> RIGHT at period 36 (digital override).
//  6. Running at 36 with counter=25, switch analog to +127 (period 7) -> step on next edge, then every 7 cycles.

Source files
------------

// File: rtl/steer_quad_gen.sv
`default_nettype none
// ============================================================================
// Module      : steer_quad_gen
// Description : Digital/analog steering request to 2-bit quadrature {A,B}.
// Revision    : 1.0 - initial release
// ============================================================================
module steer_quad_gen #(
    parameter int CLKDIV_MAX = 22500,
    parameter int CLKDIV_MIN = 2000,
    parameter int DEADZONE   = 8
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       left,
    input  logic       right,
    input  logic       use_analog,
    input  logic [7:0] analog_x,
    output logic [1:0] steer,
    output logic       moving
);

    localparam int PER_W  = $clog2(CLKDIV_MAX + 1);
    localparam int PROD_W = PER_W + 7;

    localparam logic [PER_W-1:0] C_PER_MAX = PER_W'(CLKDIV_MAX);
    localparam logic [PER_W-1:0] C_PER_MIN = PER_W'(CLKDIV_MIN);
    localparam logic [PER_W-1:0] C_SPAN    = PER_W'(CLKDIV_MAX - CLKDIV_MIN);
    localparam logic [PER_W-1:0] C_ONE     = PER_W'(1);
    localparam logic [6:0]       C_DZ      = 7'(DEADZONE);

    typedef enum logic [1:0] {
        DIR_IDLE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_L = 2'd1,
        ST_RUN_R = 2'd2
    } state_t;

    dir_t               dir_d,    dir_q;
    logic [PER_W-1:0]   period_d, period_q;
    state_t             state_d,  state_q;
    logic [PER_W-1:0]   cnt_d,    cnt_q;
    logic [1:0]         steer_d,  steer_q;
    logic               moving_d, moving_q;

    logic [7:0]         w_abs;
    logic [6:0]         w_mag;
    logic [6:0]         w_excess;
    logic [PROD_W-1:0]  w_prod;
    logic [PER_W-1:0]   w_reduce;
    state_t             w_target;

    // Gray sequence 00->01->11->10 when fwd, reversed otherwise.
    function automatic logic [1:0] gray_step(input logic [1:0] p, input logic fwd);
        logic [1:0] n;
        case (p)
            2'b00:   n = fwd ? 2'b01 : 2'b10;
            2'b01:   n = fwd ? 2'b11 : 2'b00;
            2'b11:   n = fwd ? 2'b10 : 2'b01;
            default: n = fwd ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    // Stage 1: request decode and analog rate scaling.
    always_comb begin
        w_abs    = analog_x[7] ? (~analog_x + 8'd1) : analog_x;
        w_mag    = w_abs[7] ? 7'd127 : w_abs[6:0];
        w_excess = (w_mag > C_DZ) ? (w_mag - C_DZ) : 7'd0;
        w_prod   = PROD_W'(w_excess) * PROD_W'(C_SPAN);
        w_reduce = PER_W'(w_prod >> 7);

        dir_d    = DIR_IDLE;
        period_d = C_PER_MAX;
        if (left ^ right) begin
            dir_d = left ? DIR_LEFT : DIR_RIGHT;
        end else if (!left && !right && use_analog && (w_mag > C_DZ)) begin
            dir_d    = analog_x[7] ? DIR_LEFT : DIR_RIGHT;
            period_d = (w_reduce > C_SPAN) ? C_PER_MIN : (C_PER_MAX - w_reduce);
        end
    end

    // Stage 2: the engine state mirrors the request register, so a direction
    // change is detected on the same edge that dir registers.  This lands the
    // first step exactly one period after that edge.
    always_comb begin
        case (dir_d)
            DIR_LEFT:  w_target = ST_RUN_L;
            DIR_RIGHT: w_target = ST_RUN_R;
            default:   w_target = ST_IDLE;
        endcase

        state_d  = w_target;
        cnt_d    = cnt_q;
        steer_d  = steer_q;
        moving_d = (w_target != ST_IDLE);

        if (w_target == ST_IDLE) begin
            cnt_d = '0;
        end else if (w_target != state_q) begin
            cnt_d = '0;
        end else if (cnt_q >= (period_q - C_ONE)) begin
            cnt_d   = '0;
            steer_d = gray_step(steer_q, state_q == ST_RUN_R);
        end else begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            dir_q    <= DIR_IDLE;
            period_q <= C_PER_MAX;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            steer_q  <= 2'b00;
            moving_q <= 1'b0;
        end else begin
            dir_q    <= dir_d;
            period_q <= period_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            steer_q  <= steer_d;
            moving_q <= moving_d;
        end
    end

    assign steer  = steer_q;
    assign moving = moving_q;

endmodule
`default_nettype wire

// File: tb/tb_steer_quad_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_steer_quad_gen
// Description : Directed self-checking bench for steer_quad_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_steer_quad_gen;

    logic       clk;
    logic       rst;
    logic       left;
    logic       right;
    logic       use_analog;
    logic [7:0] analog_x;
    logic [1:0] steer;
    logic       moving;

    int checks   = 0;
    int failures = 0;
    logic [1:0] ph;

    steer_quad_gen #(
        .CLKDIV_MAX(36),
        .CLKDIV_MIN(4),
        .DEADZONE  (8)
    ) dut (
        .CLK       (clk),
        .reset     (rst),
        .left      (left),
        .right     (right),
        .use_analog(use_analog),
        .analog_x  (analog_x),
        .steer     (steer),
        .moving    (moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] nxt(input logic [1:0] p, input bit rgt);
        case (p)
            2'b00:   return rgt ? 2'b01 : 2'b10;
            2'b01:   return rgt ? 2'b11 : 2'b00;
            2'b11:   return rgt ? 2'b10 : 2'b01;
            default: return rgt ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Edges until steer changes, capped at max.
    task automatic wait_change(input int max, output int n);
        logic [1:0] prev;
        prev = steer;
        n = 0;
        do begin
            tick();
            n++;
        end while (steer === prev && n < max);
    endtask

    task automatic test_reset;
        rst = 1'b1; left = 0; right = 0; use_analog = 0; analog_x = 8'd0;
        repeat (3) tick();
        checks++; if (steer !== 2'b00) begin failures++; $display("FAIL reset_steer got=%b exp=00", steer); end
        checks++; if (moving !== 1'b0) begin failures++; $display("FAIL reset_moving got=%b exp=0", moving); end
        rst = 1'b0;
        repeat (40) tick();
        checks++; if (steer !== 2'b00 || moving !== 1'b0)
            begin failures++; $display("FAIL idle_after_reset got=%b/%b exp=00/0", steer, moving); end
    endtask

    task automatic test_right;
        logic [1:0] exp_seq [4];
        int n;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b11; exp_seq[2] = 2'b10; exp_seq[3] = 2'b00;
        right = 1'b1;
        tick();
        checks++; if (moving !== 1'b1 || steer !== 2'b00)
            begin failures++; $display("FAIL right_start got=%b/%b exp=00/1", steer, moving); end
        for (int i = 0; i < 4; i++) begin
            wait_change(60, n);
            checks++; if (n !== 36 || steer !== exp_seq[i])
                begin failures++; $display("FAIL right_step%0d got=%0d/%b exp=36/%b", i, n, steer, exp_seq[i]); end
        end
    endtask

    task automatic test_async_reset;
        int n;
        wait_change(60, n);
        wait_change(60, n);
        checks++; if (steer !== 2'b11)
            begin failures++; $display("FAIL pre_reset_steer got=%b exp=11", steer); end
        #2 rst = 1'b1;
        #1;
        checks++; if (steer !== 2'b00 || moving !== 1'b0)
            begin failures++; $display("FAIL async_reset got=%b/%b exp=00/0", steer, moving); end
        right = 1'b0;
        tick();
        rst = 1'b0;
        repeat (36) tick();
        checks++; if (steer !== 2'b00 || moving !== 1'b0)
            begin failures++; $display("FAIL post_reset_idle got=%b/%b exp=00/0", steer, moving); end
    endtask

    task automatic test_left_reverse;
        int n;
        left = 1'b1;
        tick();
        checks++; if (moving !== 1'b1)
            begin failures++; $display("FAIL left_moving got=%b exp=1", moving); end
        wait_change(60, n);
        checks++; if (n !== 36 || steer !== 2'b10)
            begin failures++; $display("FAIL left_step0 got=%0d/%b exp=36/10", n, steer); end
        wait_change(60, n);
        checks++; if (n !== 36 || steer !== 2'b11)
            begin failures++; $display("FAIL left_step1 got=%0d/%b exp=36/11", n, steer); end
        left = 1'b0; right = 1'b1;
        tick();
        checks++; if (steer !== 2'b11 || moving !== 1'b1)
            begin failures++; $display("FAIL reversal_nostep got=%b/%b exp=11/1", steer, moving); end
        wait_change(60, n);
        checks++; if (n !== 36 || steer !== 2'b10)
            begin failures++; $display("FAIL reversal_step got=%0d/%b exp=36/10", n, steer); end
        right = 1'b0;
        tick(); tick();
        ph = 2'b10;
    endtask

    task automatic test_analog;
        logic [7:0] ax  [4];
        int         per [4];
        bit         rgt [4];
        logic [7:0] dz  [2];
        int n;
        ax[0] = 8'd127; per[0] = 7;  rgt[0] = 1;
        ax[1] = 8'd72;  per[1] = 20; rgt[1] = 1;
        ax[2] = 8'd9;   per[2] = 36; rgt[2] = 1;
        ax[3] = 8'h80;  per[3] = 7;  rgt[3] = 0;
        use_analog = 1'b1;
        for (int i = 0; i < 4; i++) begin
            analog_x = 8'd0;
            tick(); tick();
            analog_x = ax[i];
            tick();
            checks++; if (moving !== 1'b1)
                begin failures++; $display("FAIL analog%0d_moving got=%b exp=1", i, moving); end
            for (int k = 0; k < 2; k++) begin
                wait_change(60, n);
                ph = nxt(ph, rgt[i]);
                checks++; if (n !== per[i] || steer !== ph)
                    begin failures++; $display("FAIL analog%0d_step%0d got=%0d/%b exp=%0d/%b", i, k, n, steer, per[i], ph); end
            end
        end
        dz[0] = 8'd8; dz[1] = 8'hF8;
        for (int i = 0; i < 2; i++) begin
            analog_x = dz[i];
            tick(); tick();
            checks++; if (moving !== 1'b0)
                begin failures++; $display("FAIL deadzone%0d_moving got=%b exp=0", i, moving); end
            repeat (40) tick();
            checks++; if (steer !== ph)
                begin failures++; $display("FAIL deadzone%0d_frozen got=%b exp=%b", i, steer, ph); end
        end
    endtask

    task automatic test_both_pressed;
        int n;
        analog_x = 8'd127;
        left = 1'b1; right = 1'b1;
        tick(); tick();
        checks++; if (moving !== 1'b0)
            begin failures++; $display("FAIL both_moving got=%b exp=0", moving); end
        repeat (20) tick();
        checks++; if (steer !== ph)
            begin failures++; $display("FAIL both_frozen got=%b exp=%b", steer, ph); end
        left = 1'b0;
        tick();
        checks++; if (moving !== 1'b1)
            begin failures++; $display("FAIL override_moving got=%b exp=1", moving); end
        wait_change(60, n);
        ph = nxt(ph, 1);
        checks++; if (n !== 36 || steer !== ph)
            begin failures++; $display("FAIL override_step got=%0d/%b exp=36/%b", n, steer, ph); end
    endtask

    task automatic test_period_change;
        int n;
        repeat (25) tick();
        right = 1'b0;
        tick();
        checks++; if (steer !== ph)
            begin failures++; $display("FAIL pchg_nostep got=%b exp=%b", steer, ph); end
        tick();
        ph = nxt(ph, 1);
        checks++; if (steer !== ph)
            begin failures++; $display("FAIL pchg_immediate got=%b exp=%b", steer, ph); end
        wait_change(60, n);
        ph = nxt(ph, 1);
        checks++; if (n !== 7 || steer !== ph)
            begin failures++; $display("FAIL pchg_interval got=%0d/%b exp=7/%b", n, steer, ph); end
    endtask

    initial begin
        ph = 2'b00;
        test_reset();
        test_right();
        test_async_reset();
        test_left_reverse();
        test_analog();
        test_both_pressed();
        test_period_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
